// File: rtl/mem_stage_if.sv
// Data-memory request bus between the memory stage (master) and the data memory (slave).
// The request fields are qualified by dm_req; completion is signalled by dm_ack.
interface mem_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ack
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_rdata,
        output dm_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: runs loads/stores against data memory with a bounded wait,
// passes ALU-only ops through in one cycle and resolves branches into a redirect pulse.
module mem_stage (
    input  logic         clk,
    input  logic         rst,
    // Ex stage
    input  logic         ex_valid,
    input  logic         MEMWR_Ex,
    input  logic         MEM2REG_Ex,
    input  logic         REGWR_Ex,
    input  logic         BRANCH_Ex,
    input  logic         BRANCHNE_Ex,
    input  logic         zero,
    input  logic         overflow,
    input  logic [31:0]  ALUout,
    input  logic [31:0]  tran_addr,
    input  logic [4:0]   regwr,
    input  logic [31:0]  reg_data,
    // Data memory
    mem_stage_if.master  dm,
    // Front end
    output logic         pc_redirect,
    output logic [31:0]  redirect_pc,
    output logic         stall,
    // Mem/WB
    output logic         wb_valid,
    output logic         MEM2REG_Mem,
    output logic         REGWR_Mem,
    output logic [4:0]   regwr_Mem,
    output logic [31:0]  ALUout_Mem,
    output logic [31:0]  mem_data,
    output logic         mem_err
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    // Last ACCESS cycle index before the wait counter would reach its limit of 15.
    localparam logic [3:0] TIMEOUT_LAST = 4'd14;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_is_load;

    logic        r_dm_req;
    logic        r_dm_we;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;

    logic        r_wb_valid;
    logic        r_mem_err;
    logic        r_mem2reg;
    logic        r_regwr_en;
    logic [4:0]  r_regwr;
    logic [31:0] r_aluout;
    logic [31:0] r_mem_data;
    logic        r_pc_redirect;
    logic [31:0] r_redirect_pc;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_is_store;
    logic        w_is_load;
    logic        w_misaligned;
    logic        w_taken;
    logic        w_alu_done;
    logic        w_misalign_done;
    logic        w_start;
    logic        w_ack_done;
    logic        w_timeout;
    logic        w_stall;

    // Store wins when both memory controls are set.
    function automatic logic f_is_load(input logic memwr, input logic mem2reg);
        return mem2reg & ~memwr;
    endfunction

    // Ex is only sampled in IDLE; during ACCESS it is held and ignored.
    assign w_accept        = ex_valid & (r_state == S_IDLE);
    assign w_is_store      = MEMWR_Ex;
    assign w_is_load       = f_is_load(MEMWR_Ex, MEM2REG_Ex);
    assign w_is_mem        = MEMWR_Ex | MEM2REG_Ex;
    assign w_misaligned    = (ALUout[1:0] != 2'b00);
    assign w_taken         = (BRANCH_Ex & zero) | (BRANCHNE_Ex & ~zero);
    assign w_alu_done      = w_accept & ~w_is_mem;
    assign w_misalign_done = w_accept & w_is_mem & w_misaligned;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, stall and access start/finish strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_start     = 1'b0;
        w_ack_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mem && !w_misaligned) begin
                    w_state_nxt = S_ACCESS;
                    w_stall     = 1'b1;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCESS: begin
                w_stall = 1'b1;
                if (dm.dm_ack) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ACCESS;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Wait counter: counts ACCESS cycles that end without an acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_start) begin
            r_cnt <= 4'd0;
        end else if ((r_state == S_ACCESS) && !dm.dm_ack) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Memory request: fields latched on entry and held for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= 32'd0;
            r_dm_wdata <= 32'd0;
            r_is_load  <= 1'b0;
        end else if (w_start) begin
            r_dm_req   <= 1'b1;
            r_dm_we    <= w_is_store;
            r_dm_addr  <= ALUout;
            r_dm_wdata <= reg_data;
            r_is_load  <= w_is_load;
        end else if (w_ack_done || w_timeout) begin
            r_dm_req   <= 1'b0;
        end else begin
            r_dm_req   <= r_dm_req;
        end
    end

    // Writeback payload and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_mem_err  <= 1'b0;
            r_mem2reg  <= 1'b0;
            r_regwr_en <= 1'b0;
            r_regwr    <= 5'd0;
            r_aluout   <= 32'd0;
            r_mem_data <= 32'd0;
        end else begin
            r_wb_valid <= w_alu_done | w_misalign_done | w_ack_done | w_timeout;
            r_mem_err  <= w_misalign_done | w_timeout;
            if (w_accept) begin
                r_aluout   <= ALUout;
                r_regwr    <= regwr;
                r_mem2reg  <= w_is_load;
                r_regwr_en <= REGWR_Ex & ~overflow & ~w_is_store & ~(w_is_mem & w_misaligned);
            end else if (w_timeout) begin
                r_regwr_en <= 1'b0;
            end else begin
                r_regwr_en <= r_regwr_en;
            end
            if (w_ack_done && r_is_load) begin
                r_mem_data <= dm.dm_rdata;
            end else begin
                r_mem_data <= r_mem_data;
            end
        end
    end

    // Branch resolution; memory ops never redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_redirect <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_pc_redirect <= w_alu_done & w_taken;
            if (w_alu_done && w_taken) begin
                r_redirect_pc <= tran_addr;
            end else begin
                r_redirect_pc <= r_redirect_pc;
            end
        end
    end

    assign dm.dm_req    = r_dm_req;
    assign dm.dm_we     = r_dm_we;
    assign dm.dm_addr   = r_dm_addr;
    assign dm.dm_wdata  = r_dm_wdata;

    assign stall        = w_stall;
    assign pc_redirect  = r_pc_redirect;
    assign redirect_pc  = r_redirect_pc;
    assign wb_valid     = r_wb_valid;
    assign mem_err      = r_mem_err;
    assign MEM2REG_Mem  = r_mem2reg;
    assign REGWR_Mem    = r_regwr_en;
    assign regwr_Mem    = r_regwr;
    assign ALUout_Mem   = r_aluout;
    assign mem_data     = r_mem_data;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, load/store handshakes,
// branches, misalignment, access timeout and reset in the middle of an access.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        MEMWR_Ex;
    logic        MEM2REG_Ex;
    logic        REGWR_Ex;
    logic        BRANCH_Ex;
    logic        BRANCHNE_Ex;
    logic        zero;
    logic        overflow;
    logic [31:0] ALUout;
    logic [31:0] tran_addr;
    logic [4:0]  regwr;
    logic [31:0] reg_data;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        wb_valid;
    logic        MEM2REG_Mem;
    logic        REGWR_Mem;
    logic [4:0]  regwr_Mem;
    logic [31:0] ALUout_Mem;
    logic [31:0] mem_data;
    logic        mem_err;

    int n_tests;
    int n_fail;

    mem_stage_if dmif ();

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .MEMWR_Ex    (MEMWR_Ex),
        .MEM2REG_Ex  (MEM2REG_Ex),
        .REGWR_Ex    (REGWR_Ex),
        .BRANCH_Ex   (BRANCH_Ex),
        .BRANCHNE_Ex (BRANCHNE_Ex),
        .zero        (zero),
        .overflow    (overflow),
        .ALUout      (ALUout),
        .tran_addr   (tran_addr),
        .regwr       (regwr),
        .reg_data    (reg_data),
        .dm          (dmif),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .MEM2REG_Mem (MEM2REG_Mem),
        .REGWR_Mem   (REGWR_Mem),
        .regwr_Mem   (regwr_Mem),
        .ALUout_Mem  (ALUout_Mem),
        .mem_data    (mem_data),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid    = 1'b0;
        MEMWR_Ex    = 1'b0;
        MEM2REG_Ex  = 1'b0;
        REGWR_Ex    = 1'b0;
        BRANCH_Ex   = 1'b0;
        BRANCHNE_Ex = 1'b0;
        zero        = 1'b0;
        overflow    = 1'b0;
        ALUout      = 32'd0;
        tran_addr   = 32'd0;
        regwr       = 5'd0;
        reg_data    = 32'd0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        clear_ex();
        dmif.dm_ack   = 1'b0;
        dmif.dm_rdata = 32'd0;

        // Reset state
        step();
        step();
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_dm_req", {31'd0, dmif.dm_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_pc_redirect", {31'd0, pc_redirect}, 32'd0);
        check("rst_mem_err", {31'd0, mem_err}, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        rst = 1'b0;

        // ALU-only op
        ex_valid = 1'b1; ALUout = 32'h0000_1234; regwr = 5'd5; REGWR_Ex = 1'b1;
        #1;
        check("alu_stall", {31'd0, stall}, 32'd0);
        step();
        clear_ex();
        check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("alu_ALUout_Mem", ALUout_Mem, 32'h0000_1234);
        check("alu_regwr_Mem", {27'd0, regwr_Mem}, 32'd5);
        check("alu_REGWR_Mem", {31'd0, REGWR_Mem}, 32'd1);
        check("alu_MEM2REG_Mem", {31'd0, MEM2REG_Mem}, 32'd0);
        check("alu_stall_after", {31'd0, stall}, 32'd0);
        step();
        check("alu_wb_pulse", {31'd0, wb_valid}, 32'd0);

        // ALU op with overflow suppresses the register write
        ex_valid = 1'b1; ALUout = 32'hFFFF_0000; regwr = 5'd7; REGWR_Ex = 1'b1; overflow = 1'b1;
        step();
        clear_ex();
        check("ovf_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("ovf_REGWR_Mem", {31'd0, REGWR_Mem}, 32'd0);
        check("ovf_regwr_Mem", {27'd0, regwr_Mem}, 32'd7);

        // Load, ack in the third request cycle
        ex_valid = 1'b1; MEM2REG_Ex = 1'b1; REGWR_Ex = 1'b1; ALUout = 32'h0000_0100; regwr = 5'd3;
        #1;
        check("ld_stall_idle", {31'd0, stall}, 32'd1);
        check("ld_req_idle", {31'd0, dmif.dm_req}, 32'd0);
        step();
        clear_ex();
        check("ld_req_c1", {31'd0, dmif.dm_req}, 32'd1);
        check("ld_we_c1", {31'd0, dmif.dm_we}, 32'd0);
        check("ld_addr_c1", dmif.dm_addr, 32'h0000_0100);
        check("ld_stall_c1", {31'd0, stall}, 32'd1);
        check("ld_wb_c1", {31'd0, wb_valid}, 32'd0);
        step();
        check("ld_req_c2", {31'd0, dmif.dm_req}, 32'd1);
        check("ld_stall_c2", {31'd0, stall}, 32'd1);
        check("ld_addr_c2", dmif.dm_addr, 32'h0000_0100);
        step();
        dmif.dm_ack = 1'b1; dmif.dm_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld_req_c3", {31'd0, dmif.dm_req}, 32'd1);
        check("ld_stall_c3", {31'd0, stall}, 32'd1);
        step();
        dmif.dm_ack = 1'b0; dmif.dm_rdata = 32'd0;
        check("ld_req_done", {31'd0, dmif.dm_req}, 32'd0);
        check("ld_stall_done", {31'd0, stall}, 32'd0);
        check("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("ld_mem_data", mem_data, 32'hDEAD_BEEF);
        check("ld_MEM2REG_Mem", {31'd0, MEM2REG_Mem}, 32'd1);
        check("ld_REGWR_Mem", {31'd0, REGWR_Mem}, 32'd1);
        check("ld_regwr_Mem", {27'd0, regwr_Mem}, 32'd3);
        check("ld_mem_err", {31'd0, mem_err}, 32'd0);
        step();
        check("ld_wb_pulse", {31'd0, wb_valid}, 32'd0);

        // Store (both controls set -> store), immediate ack
        ex_valid = 1'b1; MEMWR_Ex = 1'b1; MEM2REG_Ex = 1'b1; REGWR_Ex = 1'b1;
        ALUout = 32'h0000_0200; reg_data = 32'hCAFE_0001; regwr = 5'd9;
        step();
        clear_ex();
        check("st_req", {31'd0, dmif.dm_req}, 32'd1);
        check("st_we", {31'd0, dmif.dm_we}, 32'd1);
        check("st_wdata", dmif.dm_wdata, 32'hCAFE_0001);
        check("st_addr", dmif.dm_addr, 32'h0000_0200);
        dmif.dm_ack = 1'b1; dmif.dm_rdata = 32'h1111_1111;
        step();
        dmif.dm_ack = 1'b0;
        check("st_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("st_REGWR_Mem", {31'd0, REGWR_Mem}, 32'd0);
        check("st_MEM2REG_Mem", {31'd0, MEM2REG_Mem}, 32'd0);
        check("st_mem_data_kept", mem_data, 32'hDEAD_BEEF);
        check("st_req_done", {31'd0, dmif.dm_req}, 32'd0);
        step();
        check("st_wb_pulse", {31'd0, wb_valid}, 32'd0);

        // Branch-not-equal taken
        ex_valid = 1'b1; BRANCHNE_Ex = 1'b1; zero = 1'b0; tran_addr = 32'h0000_0040;
        step();
        clear_ex();
        check("bne_redirect", {31'd0, pc_redirect}, 32'd1);
        check("bne_redirect_pc", redirect_pc, 32'h0000_0040);
        check("bne_REGWR_Mem", {31'd0, REGWR_Mem}, 32'd0);
        step();
        check("bne_redirect_pulse", {31'd0, pc_redirect}, 32'd0);

        // Branch-not-equal not taken
        ex_valid = 1'b1; BRANCHNE_Ex = 1'b1; zero = 1'b1; tran_addr = 32'h0000_0060;
        step();
        clear_ex();
        check("bne_nt_redirect", {31'd0, pc_redirect}, 32'd0);
        check("bne_nt_wb_valid", {31'd0, wb_valid}, 32'd1);

        // Branch-equal taken
        ex_valid = 1'b1; BRANCH_Ex = 1'b1; zero = 1'b1; tran_addr = 32'h0000_0080;
        step();
        clear_ex();
        check("beq_redirect", {31'd0, pc_redirect}, 32'd1);
        check("beq_redirect_pc", redirect_pc, 32'h0000_0080);

        // Misaligned load
        ex_valid = 1'b1; MEM2REG_Ex = 1'b1; REGWR_Ex = 1'b1; ALUout = 32'h0000_0102; regwr = 5'd4;
        #1;
        check("mis_stall", {31'd0, stall}, 32'd0);
        step();
        clear_ex();
        check("mis_req", {31'd0, dmif.dm_req}, 32'd0);
        check("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("mis_mem_err", {31'd0, mem_err}, 32'd1);
        check("mis_REGWR_Mem", {31'd0, REGWR_Mem}, 32'd0);
        step();
        check("mis_err_pulse", {31'd0, mem_err}, 32'd0);

        // Load that never gets an ack: 15 ACCESS cycles then timeout
        ex_valid = 1'b1; MEM2REG_Ex = 1'b1; REGWR_Ex = 1'b1; ALUout = 32'h0000_0300; regwr = 5'd6;
        step();
        clear_ex();
        for (int i = 1; i <= 15; i++) begin
            check($sformatf("to_req_c%0d", i), {31'd0, dmif.dm_req}, 32'd1);
            check($sformatf("to_stall_c%0d", i), {31'd0, stall}, 32'd1);
            step();
        end
        check("to_req_done", {31'd0, dmif.dm_req}, 32'd0);
        check("to_stall_done", {31'd0, stall}, 32'd0);
        check("to_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("to_mem_err", {31'd0, mem_err}, 32'd1);
        check("to_REGWR_Mem", {31'd0, REGWR_Mem}, 32'd0);

        // Ack while idle has no effect
        dmif.dm_ack = 1'b1;
        step();
        dmif.dm_ack = 1'b0;
        check("idle_ack_wb", {31'd0, wb_valid}, 32'd0);
        check("idle_ack_err", {31'd0, mem_err}, 32'd0);

        // Reset in the middle of an access
        ex_valid = 1'b1; MEM2REG_Ex = 1'b1; REGWR_Ex = 1'b1; ALUout = 32'h0000_0400; regwr = 5'd8;
        step();
        clear_ex();
        step();
        check("rr_req_before", {31'd0, dmif.dm_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rr_req_async", {31'd0, dmif.dm_req}, 32'd0);
        check("rr_stall_async", {31'd0, stall}, 32'd0);
        check("rr_wb_async", {31'd0, wb_valid}, 32'd0);
        step();
        rst = 1'b0;

        // First edge after reset accepts an op; late ack ignored
        dmif.dm_ack = 1'b1; dmif.dm_rdata = 32'h5555_AAAA;
        ex_valid = 1'b1; ALUout = 32'h0000_0055; regwr = 5'd9; REGWR_Ex = 1'b1;
        step();
        clear_ex();
        dmif.dm_ack = 1'b0;
        check("post_rst_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("post_rst_ALUout_Mem", ALUout_Mem, 32'h0000_0055);
        check("post_rst_req", {31'd0, dmif.dm_req}, 32'd0);
        check("post_rst_mem_err", {31'd0, mem_err}, 32'd0);
        check("post_rst_mem_data", mem_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk in 1, system clock; rst in 1, asynchronous active-high reset; all state on rising clk edge.
REQ-002 SHALL accept from Ex: ex_valid in 1; MEMWR_Ex, MEM2REG_Ex, REGWR_Ex, BRANCH_Ex, BRANCHNE_Ex in 1 each; zero, overflow in 1; ALUout in 32; tran_addr in 32; regwr in 5; reg_data in 32 (store data).
REQ-003 SHALL drive data memory: dm_req out 1; dm_we out 1; dm_addr out 32; dm_wdata out 32; dm_rdata in 32; dm_ack in 1.
REQ-004 SHALL drive front end: pc_redirect out 1; redirect_pc out 32; stall out 1 (hold Ex and earlier stages).
REQ-005 SHALL drive Mem/WB: wb_valid out 1; MEM2REG_Mem out 1; REGWR_Mem out 1; regwr_Mem out 5; ALUout_Mem out 32; mem_data out 32; mem_err out 1.

Function
REQ-006 SHALL classify an accepted op (ex_valid=1, stall=0): load if MEM2REG_Ex=1, store if MEMWR_Ex=1, else ALU-only; both set = store only.
REQ-007 SHALL implement FSM IDLE, ACCESS; IDLE->ACCESS on accepted aligned load/store; ACCESS->IDLE on dm_ack=1 or timeout.
REQ-008 SHALL, on IDLE->ACCESS, register dm_addr=ALUout, dm_wdata=reg_data, dm_we=store, and assert dm_req from next cycle until the cycle dm_ack is sampled 1 (inclusive).
REQ-009 SHALL hold dm_addr/dm_we/dm_wdata stable while dm_req=1.
REQ-010 SHALL assert stall combinationally whenever state=ACCESS, and in IDLE when an accepted op is load/store; stall=0 otherwise.
REQ-011 SHALL, on dm_ack=1 in ACCESS, capture mem_data=dm_rdata (load) or keep prior mem_data (store), and pulse wb_valid=1 next cycle.
REQ-012 SHALL keep 4-bit wait counter, cleared on ACCESS entry, incremented each ACCESS cycle without dm_ack; reaching 15 without ack SHALL force IDLE, pulse mem_err=1 and wb_valid=1 with REGWR_Mem=0.
REQ-013 SHALL treat ALUout[1:0]!=0 on load/store as misaligned: no dm_req, no stall, next-cycle wb_valid=1, mem_err=1, REGWR_Mem=0.
REQ-014 SHALL pass ALU-only ops in one cycle: next edge wb_valid=1, ALUout_Mem=ALUout, regwr_Mem=regwr, MEM2REG_Mem=0, REGWR_Mem=REGWR_Ex & ~overflow.
REQ-015 SHALL compute taken = BRANCH_Ex&zero | BRANCHNE_Ex&~zero for accepted ops; on taken, register pc_redirect=1 for exactly one cycle with redirect_pc=tran_addr.
REQ-016 SHALL never combine branch with memory access; branches are ALU-only class and REGWR_Mem follows REQ-014.
REQ-017 SHALL register ALUout_Mem, regwr_Mem, MEM2REG_Mem, REGWR_Mem at acceptance of a load/store and present them with wb_valid at completion; REGWR_Mem=0 for stores and on overflow.
REQ-018 SHALL drive wb_valid, mem_err, pc_redirect as single-cycle pulses; wb_valid=0 when no op completes.
REQ-019 SHALL ignore ex_valid inputs while stall=1 (Ex holds them stable).
REQ-020 SHALL ignore dm_ack in IDLE.

Reset
REQ-021 SHALL, on rst=1 at any time including mid-ACCESS, go to IDLE immediately; all outputs 0, counter 0, no further dm_req.
REQ-022 SHALL accept a new op on the first rising clk after rst deasserts.

Verification
REQ-023 ALU op: ALUout=0x1234, regwr=5, REGWR_Ex=1, overflow=0 -> next cycle wb_valid=1, ALUout_Mem=0x1234, regwr_Mem=5, REGWR_Mem=1, stall never 1.
REQ-024 Load addr 0x100, dm_ack 3 cycles after dm_req rises, dm_rdata=0xDEADBEEF -> dm_req high 3 cycles, dm_we=0, stall high throughout, then wb_valid=1, mem_data=0xDEADBEEF, MEM2REG_Mem=1.
REQ-025 Store addr 0x200, reg_data=0xCAFE0001, immediate ack -> dm_we=1, dm_wdata=0xCAFE0001, REGWR_Mem=0, wb_valid=1 once.
REQ-026 BRANCHNE_Ex=1, zero=0, tran_addr=0x40 -> one-cycle pc_redirect=1, redirect_pc=0x40; zero=1 -> no redirect.
REQ-027 Load addr 0x102 -> no dm_req, mem_err=1, REGWR_Mem=0; load with dm_ack held 0 -> mem_err after 15 ACCESS cycles, FSM IDLE.
REQ-028 rst pulsed during ACCESS -> dm_req, stall, wb_valid 0 immediately; later dm_ack ignored.
